// File: rtl/perf_monitor_pkg.sv
`default_nettype none
// ============================================================================
// perf_monitor_pkg : shared encodings for the pipeline performance monitor
// Rev 1.0
// ============================================================================
package perf_monitor_pkg;

  typedef logic [1:0] state_t;

  localparam logic [2:0] SEL_CYC = 3'd0;
  localparam logic [2:0] SEL_RET = 3'd1;
  localparam logic [2:0] SEL_LU  = 3'd2;
  localparam logic [2:0] SEL_JB  = 3'd3;
  localparam logic [2:0] SEL_SYS = 3'd4;
  localparam logic [2:0] SEL_CPI = 3'd5;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HALT = 2'd2;

  localparam int SIG_BUBBLE  = 31;
  localparam int SIG_SYSCALL = 15;

endpackage
`default_nettype wire

// File: rtl/perf_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : CNT_W-bit event counter that sticks at all-ones
// Rev 1.0
// ============================================================================
module sat_counter
  import perf_monitor_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat_flag
);

  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = '0;
    else if (inc && !(&count))
      count_nxt = count + CNT_W'(1);
  end

  // Flag follows the value being loaded, so it rises on the edge the counter tops out.
  assign sat_flag = &count_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else
      count <= count_nxt;
  end

endmodule
`default_nettype wire

// File: rtl/perf_monitor.sv
`default_nettype none
// ============================================================================
// perf_monitor : WB-side event counters with snapshot and registered readout
// Optional macro PERF_CPI_EN adds a 16.16 CPI divider (sel=5) and cpi_busy.
// Rev 1.0
// ============================================================================
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int NUM_CNT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_signal,
  input  logic        lu,
  input  logic        JB,
  input  logic        halt,
  input  logic        clr_cnt,
  input  logic        snap,
  input  logic [2:0]  sel,
  input  logic        use_snap,
  output logic [31:0] count_out,
  output logic [1:0]  state_out,
  output logic        sat
`ifdef PERF_CPI_EN
  ,
  output logic        cpi_busy
`endif
);

  state_t           state, state_nxt;
  logic             retire;
  logic             count_en;
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] cnt_sat;
  logic [CNT_W-1:0] cnt    [NUM_CNT];
  logic [CNT_W-1:0] shadow [NUM_CNT];
  logic [31:0]      sel_word;

  assign retire = !wb_signal[SIG_BUBBLE];
  // The IDLE->RUN cycle is itself counted.
  assign count_en = (state == ST_RUN) || ((state == ST_IDLE) && retire);

  always_comb begin
    inc          = '0;
    inc[SEL_CYC] = count_en;
    inc[SEL_RET] = count_en && retire;
    inc[SEL_LU]  = count_en && lu;
    inc[SEL_JB]  = count_en && JB;
    inc[SEL_SYS] = count_en && retire && wb_signal[SIG_SYSCALL];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (retire) state_nxt = ST_RUN;
      ST_RUN: begin
        if (clr_cnt)   state_nxt = ST_IDLE;
        else if (halt) state_nxt = ST_HALT;
      end
      ST_HALT: if (clr_cnt) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  assign state_out = state;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc[i]),
      .clr      (clr_cnt),
      .count    (cnt[i]),
      .sat_flag (cnt_sat[i])
    );
  end

  // Shadows take the pre-update values, so snap+clr preserves the old totals.
  always_ff @(posedge clk) begin
    if (!rst_n)
      shadow <= '{default: '0};
    else if (snap)
      shadow <= cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt)
      sat <= 1'b0;
    else if (|cnt_sat)
      sat <= 1'b1;
  end

`ifdef PERF_CPI_EN
  localparam int DIV_W = 48;

  logic [DIV_W-1:0] quo;
  logic [31:0]      rem;
  logic [31:0]      divisor;
  logic [31:0]      cpi_res;
  logic [5:0]       div_left;
  logic             busy;
  logic [32:0]      rem_sh, rem_sub;
  logic             q_bit;
  logic [31:0]      cyc32, ret32;
  logic             unused_div;

  always_comb begin
    cyc32 = '0;
    ret32 = '0;
    cyc32[CNT_W-1:0] = cnt[SEL_CYC];
    ret32[CNT_W-1:0] = cnt[SEL_RET];
    rem_sh  = {rem, quo[DIV_W-1]};
    rem_sub = rem_sh - {1'b0, divisor};
    q_bit   = (rem_sh >= {1'b0, divisor});
  end

  // The remainder stays below the divisor, so the top subtract bit is never needed.
  assign unused_div = rem_sub[32];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      cpi_res  <= '0;
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
      div_left <= '0;
    end else if (snap) begin
      if (ret32 == '0) begin
        busy    <= 1'b0;
        cpi_res <= '1;
      end else begin
        busy     <= 1'b1;
        quo      <= {cyc32, 16'h0000};
        rem      <= '0;
        divisor  <= ret32;
        div_left <= 6'(DIV_W - 1);
      end
    end else if (busy) begin
      rem      <= q_bit ? rem_sub[31:0] : rem_sh[31:0];
      quo      <= {quo[DIV_W-2:0], q_bit};
      div_left <= div_left - 6'd1;
      if (div_left == 6'd0) begin
        busy    <= 1'b0;
        cpi_res <= (|quo[DIV_W-2:31]) ? '1 : {quo[30:0], q_bit};
      end
    end
  end

  assign cpi_busy = busy;
`endif

  always_comb begin
    sel_word = '0;
    case (sel)
      SEL_CYC, SEL_RET, SEL_LU, SEL_JB, SEL_SYS:
        sel_word[CNT_W-1:0] = use_snap ? shadow[sel] : cnt[sel];
`ifdef PERF_CPI_EN
      SEL_CPI: sel_word = cpi_res;
`endif
      default: sel_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      count_out <= '0;
    else
      count_out <= sel_word;
  end

  logic unused_sig;
  assign unused_sig = ^{wb_signal[30:16], wb_signal[14:0]};

endmodule
`default_nettype wire

// File: tb/tb_perf_monitor.sv
`default_nettype none
// ============================================================================
// tb_perf_monitor : table-driven scoreboard bench for perf_monitor (CNT_W=16)
// Rev 1.0
// ============================================================================
module tb_perf_monitor;
  import perf_monitor_pkg::*;

  localparam int          CNT_W = 16;
  localparam logic [31:0] BUB   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_signal = BUB;
  logic        lu = 1'b0, JB = 1'b0, halt = 1'b0, clr_cnt = 1'b0, snap = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        use_snap = 1'b0;
  logic [31:0] count_out;
  logic [1:0]  state_out;
  logic        sat;
`ifdef PERF_CPI_EN
  logic        cpi_busy;
`endif

  perf_monitor #(.CNT_W(CNT_W), .NUM_CNT(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_signal (wb_signal),
    .lu        (lu),
    .JB        (JB),
    .halt      (halt),
    .clr_cnt   (clr_cnt),
    .snap      (snap),
    .sel       (sel),
    .use_snap  (use_snap),
    .count_out (count_out),
    .state_out (state_out),
    .sat       (sat)
`ifdef PERF_CPI_EN
    ,
    .cpi_busy  (cpi_busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wb;
    logic        lu, jb, halt, clr, snap;
    logic [2:0]  sel;
    logic        use_snap;
    int          rep;
    logic        chk;
    logic [31:0] exp_cnt;
    logic [1:0]  exp_st;
    logic        exp_sat;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] sb[$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic vec_t row(logic [31:0] wb, logic l, logic j, logic h, logic c,
                               logic s, int rep, logic [1:0] st, logic st_sat);
    vec_t v;
    v.wb = wb; v.lu = l; v.jb = j; v.halt = h; v.clr = c; v.snap = s;
    v.sel = 3'd0; v.use_snap = 1'b0; v.rep = rep; v.chk = 1'b0;
    v.exp_cnt = '0; v.exp_st = st; v.exp_sat = st_sat;
    return v;
  endfunction

  function automatic vec_t rd(logic [2:0] s, logic us, logic [31:0] e,
                              logic [1:0] st, logic st_sat);
    vec_t v;
    v = row(BUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, st, st_sat);
    v.sel = s; v.use_snap = us; v.chk = 1'b1; v.exp_cnt = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    for (int r = 0; r < v.rep; r++) begin
      wb_signal = v.wb; lu = v.lu; JB = v.jb; halt = v.halt;
      clr_cnt = v.clr; snap = v.snap; sel = v.sel; use_snap = v.use_snap;
      if (v.chk && r == v.rep - 1) sb.push_back(v.exp_cnt);
      @(posedge clk); #1;
    end
    clr_cnt = 1'b0;
    snap    = 1'b0;
    if (v.chk) begin
      if (sb.size() == 0) check($sformatf("v%0d_scoreboard", idx), 32'd0, 32'd1);
      else check($sformatf("v%0d_count", idx), count_out, sb.pop_front());
    end
    check($sformatf("v%0d_state", idx), {30'd0, state_out}, {30'd0, v.exp_st});
    check($sformatf("v%0d_sat", idx), {31'd0, sat}, {31'd0, v.exp_sat});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;

    // Counting, hazards, halt/freeze, then snapshot behaviour.
    vt.push_back(row(BUB,   0,0,0,0,0, 3,  ST_IDLE, 0));
    vt.push_back(row(32'h0, 0,0,0,0,0, 1,  ST_RUN,  0));
    vt.push_back(row(32'h0, 0,0,0,0,0, 9,  ST_RUN,  0));
    vt.push_back(rd(SEL_CYC, 0, 32'd10, ST_RUN, 0));
    vt.push_back(rd(SEL_RET, 0, 32'd10, ST_RUN, 0));
    vt.push_back(row(BUB,   1,0,0,0,0, 3,  ST_RUN,  0));
    vt.push_back(row(BUB,   1,1,0,0,0, 1,  ST_RUN,  0));
    vt.push_back(row(BUB,   0,1,0,0,0, 1,  ST_RUN,  0));
    vt.push_back(rd(SEL_LU,  0, 32'd4,  ST_RUN, 0));
    vt.push_back(rd(SEL_JB,  0, 32'd2,  ST_RUN, 0));
    vt.push_back(rd(SEL_CYC, 0, 32'd19, ST_RUN, 0));
    vt.push_back(row(32'h0000_8000, 0,0,1,0,0, 1, ST_HALT, 0));
    vt.push_back(row(32'h0, 1,1,1,0,0, 20, ST_HALT, 0));
    vt.push_back(rd(SEL_CYC, 0, 32'd21, ST_HALT, 0));
    vt.push_back(rd(SEL_RET, 0, 32'd11, ST_HALT, 0));
    vt.push_back(rd(SEL_LU,  0, 32'd4,  ST_HALT, 0));
    vt.push_back(rd(SEL_JB,  0, 32'd2,  ST_HALT, 0));
    vt.push_back(rd(SEL_SYS, 0, 32'd1,  ST_HALT, 0));
    vt.push_back(rd(SEL_CPI, 0, 32'd0,  ST_HALT, 0));
    vt.push_back(rd(3'd6,    0, 32'd0,  ST_HALT, 0));
    vt.push_back(row(BUB,   0,0,0,1,0, 1,  ST_IDLE, 0));
    vt.push_back(rd(SEL_CYC, 0, 32'd0,  ST_IDLE, 0));
    vt.push_back(row(32'h0, 0,0,0,0,0, 100, ST_RUN, 0));
    vt.push_back(row(BUB,   0,0,0,0,1, 1,  ST_RUN,  0));
    vt.push_back(row(BUB,   0,0,0,0,0, 49, ST_RUN,  0));
    vt.push_back(rd(SEL_CYC, 0, 32'd150, ST_RUN, 0));
    vt.push_back(rd(SEL_CYC, 1, 32'd100, ST_RUN, 0));
    vt.push_back(row(BUB,   0,0,0,1,1, 1,  ST_IDLE, 0));
    vt.push_back(rd(SEL_CYC, 1, 32'd152, ST_IDLE, 0));
    vt.push_back(rd(SEL_RET, 1, 32'd100, ST_IDLE, 0));
    vt.push_back(rd(SEL_CYC, 0, 32'd0,   ST_IDLE, 0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_count", count_out, 32'd0);
    check("reset_state", {30'd0, state_out}, {30'd0, ST_IDLE});
    check("reset_sat", {31'd0, sat}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Saturation at 16 bits: counter sticks at FFFF, sat rises on that edge.
    wb_signal = 32'h0;
    for (int i = 1; i <= 65540; i++) begin
      @(posedge clk); #1;
      if (i == 65534) check("sat_below_top", {31'd0, sat}, 32'd0);
      if (i == 65535) check("sat_at_top", {31'd0, sat}, 32'd1);
    end
    apply(rd(SEL_CYC, 0, 32'h0000_FFFF, ST_RUN, 1), 100);
    apply(rd(SEL_RET, 0, 32'h0000_FFFF, ST_RUN, 1), 101);
    apply(rd(SEL_LU,  0, 32'd0,         ST_RUN, 1), 102);
    apply(row(BUB, 0,0,0,1,0, 1, ST_IDLE, 0), 103);
    apply(rd(SEL_CYC, 0, 32'd0, ST_IDLE, 0), 104);

`ifdef PERF_CPI_EN
    apply(row(32'h0, 0,0,0,0,0, 200, ST_RUN, 0), 200);
    apply(row(BUB,   0,0,0,0,0, 100, ST_RUN, 0), 201);
    apply(row(BUB,   0,0,0,0,1, 1,   ST_RUN, 0), 202);
    busy_n = 0;
    while (cpi_busy && busy_n < 100) begin
      busy_n++;
      @(posedge clk); #1;
    end
    check("cpi_busy_cycles", busy_n, 32'd48);
    apply(rd(SEL_CPI, 0, 32'h0001_8000, ST_RUN, 0), 203);
    apply(row(BUB, 0,0,0,1,0, 1, ST_IDLE, 0), 204);
    apply(row(BUB, 0,0,0,0,1, 1, ST_IDLE, 0), 205);
    check("cpi_busy_div0", {31'd0, cpi_busy}, 32'd0);
    apply(rd(SEL_CPI, 0, 32'hFFFF_FFFF, ST_IDLE, 0), 206);
`else
    busy_n = 0;
    apply(rd(SEL_CPI, 0, 32'd0, ST_IDLE, 0), 200);
`endif

    // Reset in the middle of a run, with snap asserted, clears everything.
    apply(row(32'h0, 0,0,0,0,0, 5, ST_RUN, 0), 300);
    wb_signal = 32'h0; snap = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_count", count_out, 32'd0);
    check("midrst_state", {30'd0, state_out}, {30'd0, ST_IDLE});
    check("midrst_sat", {31'd0, sat}, 32'd0);
    snap = 1'b0; rst_n = 1'b1; wb_signal = BUB;
    apply(rd(SEL_CYC, 1, 32'd0, ST_IDLE, 0), 301);
    apply(rd(SEL_CYC, 0, 32'd0, ST_IDLE, 0), 302);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
